level_hold_tx: RTL and testbench

Transmit-side shaper for slow board-level control and presence signals driven to a peer CPLD or connector. The peer filters these lines with a tick-based debouncer. This block guarantees that every level it drives stays stable for at least `hold_time` full tick periods, so no edge is lost at the far end. Requests that toggle faster than that are coalesced and flagged. It sits between internal sequencing logic and the output pin.

---
 rtl/level_hold_tx_if.sv | 21 ++
 rtl/level_hold_tx.sv | 99 +++++++++
 tb/tb_level_hold_tx.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/level_hold_tx_if.sv
// rtl/level_hold_tx_if.sv - request/status bundle between sequencing logic and the level shaper
interface level_hold_tx_if;
    logic        iTick;
    logic [15:0] hold_time;
    logic        level_req;
    logic        clr_ovr;
    logic        level_out;
    logic        chg_pulse;
    logic        busy;
    logic        ovr;

    modport master (
        output iTick, hold_time, level_req, clr_ovr,
        input  level_out, chg_pulse, busy, ovr
    );

    modport slave (
        input  iTick, hold_time, level_req, clr_ovr,
        output level_out, chg_pulse, busy, ovr
    );
endinterface

// File: rtl/level_hold_tx.sv
// rtl/level_hold_tx.sv - minimum-hold shaper for slow board-level control lines
// Every driven level stays stable for at least hold_time tick periods; faster request pulses are coalesced into ovr.
module level_hold_tx #(
    parameter logic RST_LEVEL = 1'b0
) (
    input  logic            iCLK,
    input  logic            iRst_n,
    level_hold_tx_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        s1_q, s2_q;
    logic        level_q, level_d;
    logic        chg_q, chg_d;
    logic [16:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        ovr_q, ovr_d;
    logic        ovr_set;
    logic [16:0] load_val;

    // One extra count so a change landing mid-period still gets hold_time whole periods.
    assign load_val = {1'b0, bus.hold_time} + 17'd1;

    always_ff @(posedge iCLK or negedge iRst_n) begin
        if (!iRst_n) begin
            s1_q    <= RST_LEVEL;
            s2_q    <= RST_LEVEL;
            state_q <= IDLE;
            level_q <= RST_LEVEL;
            chg_q   <= 1'b0;
            cnt_q   <= 17'd0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            s1_q    <= bus.level_req;
            s2_q    <= s1_q;
            state_q <= state_d;
            level_q <= level_d;
            chg_q   <= chg_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        chg_d   = 1'b0;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovr_set = 1'b0;
        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (s2_q != level_q) begin
                    level_d = s2_q;
                    chg_d   = 1'b1;
                    if (bus.hold_time != 16'd0) begin
                        cnt_d   = load_val;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.iTick && cnt_q == 17'd1) begin
                    // Expiry edge: a still-differing request is taken immediately and re-arms the hold.
                    pend_d = 1'b0;
                    if (s2_q != level_q) begin
                        level_d = s2_q;
                        chg_d   = 1'b1;
                        cnt_d   = load_val;
                    end else begin
                        cnt_d   = 17'd0;
                        state_d = IDLE;
                    end
                end else begin
                    if (bus.iTick && cnt_q != 17'd0) begin
                        cnt_d = cnt_q - 17'd1;
                    end
                    if (s2_q != level_q) begin
                        pend_d = 1'b1;
                    end else if (pend_q) begin
                        ovr_set = 1'b1;
                        pend_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        ovr_d = ovr_set | (ovr_q & ~bus.clr_ovr);
    end

    assign bus.level_out = level_q;
    assign bus.chg_pulse = chg_q;
    assign bus.busy      = (state_q == HOLD);
    assign bus.ovr       = ovr_q;
endmodule

// File: tb/tb_level_hold_tx.sv
// tb/tb_level_hold_tx.sv - self-checking bench for level_hold_tx
module tb_level_hold_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        req = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] hold = 16'd0;
    logic        last_tick = 1'b0;
    int          tick_mode = 0;
    int          tick_period = 1;
    int          tick_phase = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    level_hold_tx_if bus1 ();
    level_hold_tx_if bus0 ();

    assign bus1.iTick = tick;
    assign bus1.hold_time = hold;
    assign bus1.level_req = req;
    assign bus1.clr_ovr = clr;
    assign bus0.iTick = tick;
    assign bus0.hold_time = hold;
    assign bus0.level_req = req;
    assign bus0.clr_ovr = clr;

    level_hold_tx #(.RST_LEVEL(1'b1)) dut1 (.iCLK(clk), .iRst_n(rst_n), .bus(bus1));
    level_hold_tx #(.RST_LEVEL(1'b0)) dut0 (.iCLK(clk), .iRst_n(rst_n), .bus(bus0));

    // Reference for dut1: counts ticks up since the last output change and compares with the hold length.
    typedef struct packed {
        logic        out;
        logic        chg;
        logic        on;
        logic        away;
        logic        ovr;
        logic [16:0] len;
        logic [16:0] ticks;
    } mstate_t;

    mstate_t m;
    logic    m_s1, m_s2;

    function automatic mstate_t model_next(mstate_t c, logic s2, logic tk, logic [15:0] h, logic cl);
        mstate_t     n;
        logic        setv;
        logic [16:0] t;
        n    = c;
        setv = 1'b0;
        t    = 17'd0;
        n.chg = 1'b0;
        if (c.on) begin
            t = c.ticks + (tk ? 17'd1 : 17'd0);
            if (t >= c.len) begin
                n.away  = 1'b0;
                n.ticks = 17'd0;
                if (s2 != c.out) begin
                    n.out = s2;
                    n.chg = 1'b1;
                    n.len = {1'b0, h} + 17'd1;
                end else begin
                    n.on = 1'b0;
                end
            end else begin
                n.ticks = t;
                if (s2 != c.out) n.away = 1'b1;
                else if (c.away) begin
                    setv   = 1'b1;
                    n.away = 1'b0;
                end
            end
        end else if (s2 != c.out) begin
            n.out   = s2;
            n.chg   = 1'b1;
            n.on    = (h != 16'd0);
            n.len   = {1'b0, h} + 17'd1;
            n.ticks = 17'd0;
            n.away  = 1'b0;
        end
        if (setv) n.ovr = 1'b1;
        else if (cl) n.ovr = 1'b0;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= 1'b1;
            m_s2 <= 1'b1;
            m    <= '{out: 1'b1, chg: 1'b0, on: 1'b0, away: 1'b0, ovr: 1'b0, len: 17'd0, ticks: 17'd0};
        end else begin
            m_s1 <= req;
            m_s2 <= m_s1;
            m    <= model_next(m, m_s2, tick, hold, clr);
        end
    end

    task automatic cycle();
        case (tick_mode)
            1: begin
                tick = (tick_phase == tick_period - 1);
                tick_phase = (tick_phase + 1) % tick_period;
            end
            2: tick = ($urandom_range(0, 3) == 0);
            default: ;
        endcase
        last_tick = tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; hold = 16'd0; clr = 1'b0; tick = 1'b0; tick_mode = 0;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (bus1.level_out !== 1'b1) begin errors++; $display("FAIL reset_level got %b want 1", bus1.level_out); end
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus1.busy); end
        checks++; if (bus1.ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", bus1.ovr); end
        checks++; if (bus0.level_out !== 1'b0) begin errors++; $display("FAIL reset_level0 got %b want 0", bus0.level_out); end
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            checks++;
            if (bus1.level_out !== (k < 3 ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL release_level edge %0d got %b want %b", k, bus1.level_out, (k < 3 ? 1'b1 : 1'b0));
            end
            checks++;
            if (bus1.chg_pulse !== (k == 3 ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL release_chg edge %0d got %b want %b", k, bus1.chg_pulse, (k == 3 ? 1'b1 : 1'b0));
            end
        end
    endtask

    task automatic test_basic_hold();
        int ticks, busy_bad, n;
        bit rose, fell, idle;
        hold = 16'd4; tick_mode = 1; tick_period = 10; tick_phase = 0; req = 1'b1;
        rose = 0;
        for (n = 0; n < 20 && !rose; n++) begin cycle(); rose = (bus1.level_out === 1'b1); end
        checks++; if (!rose) begin errors++; $display("FAIL basic_rise got level %b want 1 within 20 cycles", bus1.level_out); end
        checks++; if (bus1.chg_pulse !== 1'b1 || bus1.busy !== 1'b1) begin
            errors++; $display("FAIL basic_rise_flags got chg %b busy %b want 1 1", bus1.chg_pulse, bus1.busy);
        end
        req = 1'b0;
        ticks = 0; busy_bad = 0; fell = 0;
        for (n = 0; n < 100 && !fell; n++) begin
            cycle();
            if (last_tick) ticks++;
            if (bus1.busy !== 1'b1) busy_bad++;
            fell = (bus1.level_out === 1'b0);
        end
        checks++; if (!fell || ticks != 5) begin errors++; $display("FAIL basic_fall_tick got tick %0d fell %0d want tick 5", ticks, fell); end
        checks++; if (bus1.chg_pulse !== 1'b1) begin errors++; $display("FAIL basic_fall_chg got %b want 1", bus1.chg_pulse); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL basic_busy_gap got %0d low cycles want 0", busy_bad); end
        checks++; if (bus1.ovr !== 1'b0) begin errors++; $display("FAIL basic_ovr got %b want 0", bus1.ovr); end
        ticks = 0; idle = 0;
        for (n = 0; n < 100 && !idle; n++) begin
            cycle();
            if (last_tick) ticks++;
            idle = (bus1.busy === 1'b0);
        end
        checks++; if (!idle || ticks != 5) begin errors++; $display("FAIL basic_second_hold got tick %0d idle %0d want tick 5", ticks, idle); end
    endtask

    task automatic test_coalesce();
        int n, chgs;
        bit rose, idle;
        hold = 16'd3;
        clr = 1'b1; cycle(); clr = 1'b0;
        req = 1'b1; rose = 0;
        for (n = 0; n < 20 && !rose; n++) begin cycle(); rose = (bus1.level_out === 1'b1); end
        checks++; if (!rose) begin errors++; $display("FAIL coal_rise got level %b want 1", bus1.level_out); end
        repeat (2) cycle();
        req = 1'b0;
        repeat (5) cycle();
        req = 1'b1;
        chgs = 0; idle = 0;
        for (n = 0; n < 200 && !idle; n++) begin
            cycle();
            if (bus1.chg_pulse === 1'b1) chgs++;
            idle = (bus1.busy === 1'b0);
        end
        checks++; if (!idle) begin errors++; $display("FAIL coal_timeout got busy %b want 0", bus1.busy); end
        checks++; if (chgs != 0 || bus1.level_out !== 1'b1) begin
            errors++; $display("FAIL coal_extra_change got %0d changes level %b want 0 changes level 1", chgs, bus1.level_out);
        end
        repeat (4) cycle();
        checks++; if (bus1.ovr !== 1'b1) begin errors++; $display("FAIL coal_ovr got %b want 1", bus1.ovr); end
        clr = 1'b1; cycle(); clr = 1'b0;
        checks++; if (bus1.ovr !== 1'b0) begin errors++; $display("FAIL coal_clr got %b want 0", bus1.ovr); end
    endtask

    task automatic test_zero_hold();
        logic samp [40];
        int chgs;
        hold = 16'd0; tick_mode = 2; req = bus1.level_out; chgs = 0;
        for (int n = 0; n < 40; n++) begin
            if (n % 4 == 0 && n < 32) req = ~req;
            cycle();
            samp[n] = req;
            if (bus1.chg_pulse === 1'b1) chgs++;
            if (n >= 2) begin
                checks++;
                if (bus1.level_out !== samp[n-2]) begin
                    errors++; $display("FAIL zero_follow cycle %0d got %b want %b", n, bus1.level_out, samp[n-2]);
                end
            end
            checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL zero_busy cycle %0d got %b want 0", n, bus1.busy); end
        end
        checks++; if (chgs != 8) begin errors++; $display("FAIL zero_chg_count got %0d want 8", chgs); end
    endtask

    task automatic test_edge_cases();
        bit hit;
        hold = 16'hFFFF; tick_mode = 1; tick_period = 1; tick_phase = 0;
        req = ~bus1.level_out; hit = 0;
        for (int n = 0; n < 10 && !hit; n++) begin cycle(); hit = (bus1.chg_pulse === 1'b1); end
        checks++; if (!hit) begin errors++; $display("FAIL edge_change got chg %b want 1", bus1.chg_pulse); end
        checks++; if (dut1.cnt_q !== 17'h10000) begin errors++; $display("FAIL edge_load got %h want 10000", dut1.cnt_q); end
        hold = 16'd2;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            checks++;
            if (dut1.cnt_q !== 17'h10000 - 17'(k)) begin
                errors++; $display("FAIL edge_midhold cycle %0d got %h want %h", k, dut1.cnt_q, 17'h10000 - 17'(k));
            end
        end
        checks++; if (bus1.busy !== 1'b1) begin errors++; $display("FAIL edge_busy got %b want 1", bus1.busy); end
    endtask

    task automatic test_reset_mid_hold();
        bit rose;
        int k;
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1; req = 1'b1; hold = 16'd3; tick_mode = 0; tick = 1'b0;
        rose = 0;
        for (k = 1; k <= 10 && !rose; k++) begin cycle(); rose = (bus0.level_out === 1'b1); end
        checks++; if (!rose || dut0.cnt_q !== 17'd4) begin errors++; $display("FAIL mid_load got cnt %0d rose %0d want 4", dut0.cnt_q, rose); end
        tick = 1'b1; cycle(); cycle(); tick = 1'b0;
        checks++; if (dut0.cnt_q !== 17'd2 || bus0.busy !== 1'b1) begin
            errors++; $display("FAIL mid_count got cnt %0d busy %b want 2 1", dut0.cnt_q, bus0.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus0.level_out !== 1'b0 || bus0.busy !== 1'b0 || bus0.chg_pulse !== 1'b0 || bus0.ovr !== 1'b0) begin
            errors++; $display("FAIL mid_async got level %b busy %b chg %b ovr %b want 0 0 0 0", bus0.level_out, bus0.busy, bus0.chg_pulse, bus0.ovr);
        end
        checks++; if (dut0.cnt_q !== 17'd0) begin errors++; $display("FAIL mid_cnt_clear got %0d want 0", dut0.cnt_q); end
        @(posedge clk); #1;
        rst_n = 1'b1; hold = 16'd5;
        for (k = 1; k <= 4; k++) begin
            cycle();
            checks++;
            if (bus0.level_out !== (k >= 3 ? 1'b1 : 1'b0) || bus0.chg_pulse !== (k == 3 ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL mid_release edge %0d got level %b chg %b", k, bus0.level_out, bus0.chg_pulse);
            end
        end
        checks++; if (dut0.cnt_q !== 17'd6) begin errors++; $display("FAIL mid_fresh_load got %0d want 6", dut0.cnt_q); end
    endtask

    task automatic test_random();
        int shown;
        shown = 0; hold = 16'd2; tick_mode = 2;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 5) == 0) req = ~req;
            clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) hold = 16'($urandom_range(0, 3));
            cycle();
            checks++;
            if (bus1.level_out !== m.out || bus1.chg_pulse !== m.chg || bus1.busy !== m.on || bus1.ovr !== m.ovr) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random cycle %0d got out %b chg %b busy %b ovr %b want %b %b %b %b", n,
                             bus1.level_out, bus1.chg_pulse, bus1.busy, bus1.ovr, m.out, m.chg, m.on, m.ovr);
                end
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_hold();
        test_coalesce();
        test_zero_hold();
        test_edge_cases();
        test_reset_mid_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule
